mem_port_arbiter: RTL and testbench

- Shares the single PULPino-style memory port between two requesters, e.g. the instruction-side and data-side `compat_cache` instances, with round-robin arbitration.
- Allows one outstanding transaction at a time and routes each response back to the requester that owns it.
- Has a response watchdog, so a silent memory cannot hang either core.
- Sits between the caches' memory-side ports and the CW305 memory/bus interface.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/rr_arbiter_2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
//               - arb_state_t : arbiter FSM state encoding (IDLE/REQ/WAIT)
//               - mem_req_t   : latched request fields (addr, wdata, we, be)
//               - OWNER_S0/S1 : requester indices
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } mem_req_t;

    localparam logic OWNER_S0 = 1'b0;
    localparam logic OWNER_S1 = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Combinational two-way round-robin arbiter.
//               A lone request always wins; on a tie the requester that did
//               not win last time is chosen.
// Ports       : i_req[1:0] - request vector
//               i_last     - index of the previous winner
//               o_gnt[1:0] - one-hot grant (all zero when no request)
//               o_idx      - winner index (meaningful only when |i_req)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt,
    output logic       o_idx
);

    logic w_idx;

    always_comb begin
        w_idx = OWNER_S0;
        case (i_req)
            2'b10:   w_idx = OWNER_S1;
            2'b11:   w_idx = ~i_last;
            default: w_idx = OWNER_S0;
        endcase
    end

    assign o_idx = w_idx;
    assign o_gnt = {i_req[1] & w_idx, i_req[0] & ~w_idx};

endmodule : rr_arbiter_2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one PULPino-style memory port between two requesters
//               with round-robin arbitration, a single outstanding
//               transaction, response routing back to the owner and a
//               response watchdog.
// Ports       : clk, reset (async, active-high)
//               sN_* (N=0,1) : requester side - addr/wdata/we/be/req in,
//                              gnt (combinational), rvalid/rdata/error out
//               mem_*        : memory side - latched request fields and
//                              mem_req_o out, gnt/rvalid/rdata/error in
// Parameters  : TIMEOUT_CYCLES - WAIT cycles before an error response
//                                (0 disables the watchdog)
//               CNT_W          - watchdog counter width (2**CNT_W > TIMEOUT)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] s0_addr_i,
    input  logic [31:0] s0_wdata_i,
    input  logic        s0_we_i,
    input  logic [3:0]  s0_be_i,
    input  logic        s0_req_i,
    output logic        s0_gnt_o,
    output logic        s0_rvalid_o,
    output logic [31:0] s0_rdata_o,
    output logic        s0_error_o,

    input  logic [31:0] s1_addr_i,
    input  logic [31:0] s1_wdata_i,
    input  logic        s1_we_i,
    input  logic [3:0]  s1_be_i,
    input  logic        s1_req_i,
    output logic        s1_gnt_o,
    output logic        s1_rvalid_o,
    output logic [31:0] s1_rdata_o,
    output logic        s1_error_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_error_i
);

    // Last counter value before the watchdog fires. Unused when disabled.
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_owner;
    logic             r_last_owner;
    mem_req_t         r_req;
    logic             r_mem_req;
    logic [CNT_W-1:0] r_wdog_cnt;

    logic             r_s0_rvalid;
    logic [31:0]      r_s0_rdata;
    logic             r_s0_error;
    logic             r_s1_rvalid;
    logic [31:0]      r_s1_rdata;
    logic             r_s1_error;

    logic [1:0]       w_arb_gnt;
    logic             w_arb_idx;
    logic             w_any_req;
    logic             w_timeout;
    logic             w_resp;
    logic [31:0]      w_resp_data;
    logic             w_resp_err;
    mem_req_t         w_s0_req;
    mem_req_t         w_s1_req;

    rr_arbiter_2 u_rr_arbiter_2 (
        .i_req  ({s1_req_i, s0_req_i}),
        .i_last (r_last_owner),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx)
    );

    assign w_any_req = s0_req_i | s1_req_i;
    assign w_s0_req  = {s0_addr_i, s0_wdata_i, s0_we_i, s0_be_i};
    assign w_s1_req  = {s1_addr_i, s1_wdata_i, s1_we_i, s1_be_i};

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wdog_cnt == c_timeout_last);

    // A real response always takes priority over a coincident timeout.
    assign w_resp      = mem_rvalid_i | w_timeout;
    assign w_resp_data = mem_rvalid_i ? mem_rdata_i : 32'h0;
    assign w_resp_err  = mem_rvalid_i ? mem_error_i : 1'b1;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and combinational grants. Grants are only issued in
    // IDLE, so a pending request is never granted while a transaction is
    // in flight.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        s0_gnt_o    = 1'b0;
        s1_gnt_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_REQ;
                    s0_gnt_o    = w_arb_gnt[0];
                    s1_gnt_o    = w_arb_gnt[1];
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_resp) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: request latch, memory request, watchdog and responses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWNER_S0;
            r_last_owner <= OWNER_S1;
            r_req        <= '0;
            r_mem_req    <= 1'b0;
            r_wdog_cnt   <= '0;
            r_s0_rvalid  <= 1'b0;
            r_s0_rdata   <= 32'h0;
            r_s0_error   <= 1'b0;
            r_s1_rvalid  <= 1'b0;
            r_s1_rdata   <= 32'h0;
            r_s1_error   <= 1'b0;
        end else begin
            r_s0_rvalid <= 1'b0;
            r_s1_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_arb_idx;
                        r_last_owner <= w_arb_idx;
                        r_req        <= (w_arb_idx == OWNER_S1) ? w_s1_req : w_s0_req;
                        r_mem_req    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        r_mem_req  <= 1'b0;
                        r_wdog_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
                    if (w_resp) begin
                        if (r_owner == OWNER_S1) begin
                            r_s1_rvalid <= 1'b1;
                            r_s1_rdata  <= w_resp_data;
                            r_s1_error  <= w_resp_err;
                        end else begin
                            r_s0_rvalid <= 1'b1;
                            r_s0_rdata  <= w_resp_data;
                            r_s0_error  <= w_resp_err;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o  = r_req.addr;
    assign mem_wdata_o = r_req.wdata;
    assign mem_we_o    = r_req.we;
    assign mem_be_o    = r_req.be;
    assign mem_req_o   = r_mem_req;

    assign s0_rvalid_o = r_s0_rvalid;
    assign s0_rdata_o  = r_s0_rdata;
    assign s0_error_o  = r_s0_error;
    assign s1_rvalid_o = r_s1_rvalid;
    assign s1_rdata_o  = r_s1_rdata;
    assign s1_error_o  = r_s1_error;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A per-cycle vector
//               table covers single read, tie arbitration, ignored strobes
//               and memory error; directed sequences cover delayed memory
//               grant, watchdog timeout with late response, and reset in WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
    logic        s0_we, s1_we, s0_req, s1_req;
    logic [3:0]  s0_be, s1_be;
    logic        s0_gnt, s0_rvalid, s0_error, s1_gnt, s1_rvalid, s1_error;
    logic [31:0] s0_rdata, s1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_req, mem_gnt, mem_rvalid, mem_error;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s0_addr_i    (s0_addr),
        .s0_wdata_i   (s0_wdata),
        .s0_we_i      (s0_we),
        .s0_be_i      (s0_be),
        .s0_req_i     (s0_req),
        .s0_gnt_o     (s0_gnt),
        .s0_rvalid_o  (s0_rvalid),
        .s0_rdata_o   (s0_rdata),
        .s0_error_o   (s0_error),
        .s1_addr_i    (s1_addr),
        .s1_wdata_i   (s1_wdata),
        .s1_we_i      (s1_we),
        .s1_be_i      (s1_be),
        .s1_req_i     (s1_req),
        .s1_gnt_o     (s1_gnt),
        .s1_rvalid_o  (s1_rvalid),
        .s1_rdata_o   (s1_rdata),
        .s1_error_o   (s1_error),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .mem_error_i  (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    // ctl   : {reset, s0_req, s1_req, mem_gnt, mem_rvalid, mem_error}
    // exp_f : {s0_gnt, s1_gnt, mem_req, s0_rvalid, s1_rvalid, s0_error, s1_error}
    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] mrd;
        logic [6:0]  exp_f;
        logic [31:0] e_addr;
        logic [31:0] e_s0rd;
        logic [31:0] e_s1rd;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s0_req     = 1'b0;
        s1_req     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_error  = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        s0_addr  = 32'h0000_0100;
        s0_wdata = 32'h0;
        s0_we    = 1'b0;
        s0_be    = 4'hF;
        s1_addr  = 32'h0000_0200;
        s1_wdata = 32'h0;
        s1_we    = 1'b0;
        s1_be    = 4'hF;
        idle_inputs();

        vecs = '{
            // Single read by s0; mem_rvalid in IDLE is ignored
            '{6'b100000, 32'h0,        7'b0000000, 32'h0,   32'h0,        32'h0},
            '{6'b000010, 32'h99,       7'b0000000, 32'h0,   32'h0,        32'h0},
            '{6'b010000, 32'h0,        7'b1000000, 32'h0,   32'h0,        32'h0},
            '{6'b000100, 32'h0,        7'b0010000, 32'h100, 32'h0,        32'h0},
            '{6'b000010, 32'hDEADBEEF, 7'b0000000, 32'h100, 32'h0,        32'h0},
            '{6'b000000, 32'h0,        7'b0001000, 32'h100, 32'hDEADBEEF, 32'h0},
            // Tie after reset, alternating owners, then s1 memory error
            '{6'b100000, 32'h0,        7'b0000000, 32'h0,   32'h0,        32'h0},
            '{6'b011000, 32'h0,        7'b1000000, 32'h0,   32'h0,        32'h0},
            '{6'b001100, 32'h0,        7'b0010000, 32'h100, 32'h0,        32'h0},
            '{6'b001010, 32'h11111111, 7'b0000000, 32'h100, 32'h0,        32'h0},
            '{6'b001000, 32'h0,        7'b0101000, 32'h100, 32'h11111111, 32'h0},
            '{6'b000100, 32'h0,        7'b0010000, 32'h200, 32'h11111111, 32'h0},
            '{6'b000010, 32'h22222222, 7'b0000000, 32'h200, 32'h11111111, 32'h0},
            '{6'b011000, 32'h0,        7'b1000100, 32'h200, 32'h11111111, 32'h22222222},
            '{6'b001100, 32'h0,        7'b0010000, 32'h100, 32'h11111111, 32'h22222222},
            '{6'b001010, 32'h33333333, 7'b0000000, 32'h100, 32'h11111111, 32'h22222222},
            '{6'b001000, 32'h0,        7'b0101000, 32'h100, 32'h33333333, 32'h22222222},
            '{6'b000100, 32'h0,        7'b0010000, 32'h200, 32'h33333333, 32'h22222222},
            '{6'b000011, 32'h44444444, 7'b0000000, 32'h200, 32'h33333333, 32'h22222222},
            '{6'b000000, 32'h0,        7'b0000101, 32'h200, 32'h33333333, 32'h44444444}
        };

        repeat (2) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            reset      = vecs[i].ctl[5];
            s0_req     = vecs[i].ctl[4];
            s1_req     = vecs[i].ctl[3];
            mem_gnt    = vecs[i].ctl[2];
            mem_rvalid = vecs[i].ctl[1];
            mem_error  = vecs[i].ctl[0];
            mem_rdata  = vecs[i].mrd;
            #1;
            check($sformatf("v%0d s0_gnt", i),    s0_gnt,    vecs[i].exp_f[6]);
            check($sformatf("v%0d s1_gnt", i),    s1_gnt,    vecs[i].exp_f[5]);
            check($sformatf("v%0d mem_req", i),   mem_req,   vecs[i].exp_f[4]);
            check($sformatf("v%0d s0_rvalid", i), s0_rvalid, vecs[i].exp_f[3]);
            check($sformatf("v%0d s1_rvalid", i), s1_rvalid, vecs[i].exp_f[2]);
            check($sformatf("v%0d s0_error", i),  s0_error,  vecs[i].exp_f[1]);
            check($sformatf("v%0d s1_error", i),  s1_error,  vecs[i].exp_f[0]);
            check($sformatf("v%0d mem_addr", i),  mem_addr,  vecs[i].e_addr);
            check($sformatf("v%0d s0_rdata", i),  s0_rdata,  vecs[i].e_s0rd);
            check($sformatf("v%0d s1_rdata", i),  s1_rdata,  vecs[i].e_s1rd);
        end

        // ---------------- Delayed memory grant on an s0 write ----------------
        @(negedge clk);
        idle_inputs();
        s0_addr  = 32'h0000_0300;
        s0_wdata = 32'hA5A5A5A5;
        s0_we    = 1'b1;
        s0_be    = 4'b0011;
        s0_req   = 1'b1;
        #1;
        check("dly s0_gnt", s0_gnt, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s0_req   = 1'b0;
            s0_addr  = 32'hFFFF_0000;
            s0_wdata = 32'h0;
            s0_we    = 1'b0;
            s0_be    = 4'hF;
            mem_gnt  = (k == 5);
            #1;
            check($sformatf("dly%0d mem_req", k),   mem_req,   1'b1);
            check($sformatf("dly%0d mem_addr", k),  mem_addr,  32'h0000_0300);
            check($sformatf("dly%0d mem_wdata", k), mem_wdata, 32'hA5A5A5A5);
            check($sformatf("dly%0d mem_we", k),    mem_we,    1'b1);
            check($sformatf("dly%0d mem_be", k),    mem_be,    4'b0011);
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        #1;
        check("dly wait mem_req", mem_req, 1'b0);
        check("dly wait mem_wdata", mem_wdata, 32'hA5A5A5A5);
        @(negedge clk);
        idle_inputs();
        #1;
        check("dly s0_rvalid", s0_rvalid, 1'b1);
        check("dly s0_rdata", s0_rdata, 32'h0000_0055);

        // ---------------- Watchdog on an s1 read, then a late response --------
        @(negedge clk);
        s1_addr = 32'h0000_0400;
        s1_req  = 1'b1;
        #1;
        check("wd s1_gnt", s1_gnt, 1'b1);
        check("wd s0_gnt", s0_gnt, 1'b0);
        @(negedge clk);
        s1_req  = 1'b0;
        mem_gnt = 1'b1;
        #1;
        check("wd mem_req", mem_req, 1'b1);
        check("wd mem_addr", mem_addr, 32'h0000_0400);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            #1;
            check($sformatf("wd w%0d s1_rvalid", k), s1_rvalid, 1'b0);
        end
        @(negedge clk);
        #1;
        check("wd s1_rvalid", s1_rvalid, 1'b1);
        check("wd s1_error", s1_error, 1'b1);
        check("wd s1_rdata", s1_rdata, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0077;
        #1;
        check("wd late s1_rvalid", s1_rvalid, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("wd drop s1_rvalid", s1_rvalid, 1'b0);
        check("wd drop s0_rvalid", s0_rvalid, 1'b0);
        check("wd drop s1_rdata", s1_rdata, 32'h0);

        // ---------------- Reset while in WAIT ----------------
        @(negedge clk);
        s0_addr = 32'h0000_0500;
        s0_req  = 1'b1;
        #1;
        check("rst s0_gnt", s0_gnt, 1'b1);
        @(negedge clk);
        s0_req  = 1'b0;
        mem_gnt = 1'b1;
        #1;
        check("rst mem_req", mem_req, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rst wait mem_req", mem_req, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_be", mem_be, 4'h0);
        check("rst mem_req0", mem_req, 1'b0);
        check("rst s0_rdata", s0_rdata, 32'h0);
        check("rst s1_error", s1_error, 1'b0);
        check("rst s0_rvalid", s0_rvalid, 1'b0);
        check("rst s1_rvalid", s1_rvalid, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        s1_addr = 32'h0000_0600;
        s1_req  = 1'b1;
        #1;
        check("rst s1_gnt", s1_gnt, 1'b1);
        check("rst s0_gnt0", s0_gnt, 1'b0);
        @(negedge clk);
        s1_req  = 1'b0;
        mem_gnt = 1'b1;
        #1;
        check("rst post mem_req", mem_req, 1'b1);
        check("rst post mem_addr", mem_addr, 32'h0000_0600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
